// File: rtl/b10_field_reduction_unit.sv
// Purpose: shortens an N-digit BCD 10's-complement operand to its minimal digit count.
// Latency: eoc low for k+1 cycles for k dropped digits (1 cycle when a non-BCD digit is found).
// Backpressure: none; soc is honoured only while eoc=1, so the producer holds soc until it sees eoc=0.

// Two-digit reducer: ow is active-low, so a 0 means the MSD is pure sign extension.
module b10_field_reducer (
    input  logic [3:0] a3_a0,
    input  logic [3:0] b3_b0,
    output logic       ow
);

    logic pos_ext;
    logic neg_ext;

    always_comb begin
        pos_ext = (a3_a0 == 4'd0) && (b3_b0 < 4'd5);
        neg_ext = (a3_a0 == 4'd9) && (b3_b0 >= 4'd5);
        ow      = ~(pos_ext | neg_ext);
    end

endmodule

module b10_field_reduction_unit #(
    parameter int N  = 4,
    parameter int LW = $clog2(N + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soc,
    input  logic [4*N-1:0]    x,
    output logic              eoc,
    output logic [4*N-1:0]    z,
    output logic [LW-1:0]     len,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [4*N-1:0]     r_q;
    logic [4*N-1:0]     r_nxt;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_nxt;
    logic               err_q;
    logic               err_nxt;
    logic               ow;
    logic               reducible;
    logic               x_non_bcd;

    b10_field_reducer u_reducer (
        .a3_a0 (r_q[4*N-1:4*N-4]),
        .b3_b0 (r_q[4*N-5:4*N-8]),
        .ow    (ow)
    );

    assign reducible = ~ow;

    always_comb begin
        x_non_bcd = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[4*i +: 4] > 4'd9) begin
                x_non_bcd = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            len_q   <= LW'(1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            r_q     <= r_nxt;
            len_q   <= len_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        r_nxt     = r_q;
        len_nxt   = len_q;
        err_nxt   = err_q;
        case (state_q)
            IDLE: begin
                if (soc) begin
                    r_nxt     = x;
                    len_nxt   = LW'(N);
                    err_nxt   = x_non_bcd;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A flagged operand is returned untouched; len=1 has no digit pair left to test.
                if (err_q) begin
                    state_nxt = IDLE;
                end else if ((len_q > LW'(1)) && reducible) begin
                    r_nxt   = {r_q[4*N-5:0], 4'b0000};
                    len_nxt = len_q - LW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign eoc = (state_q == IDLE);
    assign z   = r_q;
    assign len = len_q;
    assign err = err_q;

endmodule

// File: doc/b10_field_reduction_unit.md
# b10_field_reduction_unit

Sequential controller that takes an N-digit BCD number in 10's-complement form and shortens it to its minimal field length. Each clock it checks the two most significant digits with the existing two-digit reducer, `b10_field_reducer`, and drops the MSD while the reduction is feasible. The block sits between a BCD operand register and any consumer that needs the minimal digit count, such as a formatter or a field-width negotiator. It uses the team's usual soc/eoc start/done handshake.

## Interface
- `N`, default 4, number of BCD digits in the operand; N ≥ 2.
- `LW`, default `$clog2(N+1)`, width of `len`.
- `clock`, input, 1 bit, single clock; all state changes on its rising edge.
- `reset`, input, 1 bit, asynchronous, active-high. Forces the reset values listed below.
- `soc`, input, 1 bit, start of conversion. Sampled only while `eoc`=1.
- `x`, input, 4N bits, operand; digit i is `x[4i+3:4i]`, and the LSD is digit 0.
- `eoc`, output, 1 bit, end of conversion: 1 = idle or result valid.
- `z`, output, 4N bits, reduced number, left-aligned. Its `len` most significant digits are meaningful and the remaining low digits are 0.
- `len`, output, LW bits, digit count of the reduced number, in 1..N.
- `err`, output, 1 bit, 1 = the operand contained a non-BCD digit (>9).

## Operation
- Internal working register R is 4N bits; `z` is driven directly from R. Other state: the `len` counter, the `err` flag and a 1-bit state.
- One `b10_field_reducer` instance:
  - `a3_a0` = R[4N-1:4N-4], the MSD.
  - `b3_b0` = R[4N-5:4N-8], the next digit.
  - Its `ow` output is active-low, so reducible = ~ow. That means (MSD=0 and next<5) or (MSD=9 and next≥5).
- State `IDLE` (`eoc`=1):
  - Outputs hold the last result.
  - If `soc`=1: R←x, `len`←N, `err`←(any digit of x > 9), `eoc`←0, go to `RUN`.
- State `RUN` (`eoc`=0):
  - If `err`=1: `eoc`←1, go to `IDLE`. No shift occurs.
  - Else if `len`>1 and reducible: R←{R[4N-5:0], 4'b0000} (shift left one digit, zero fill) and `len`←`len`−1. Stay in `RUN`.
  - Else: `eoc`←1, go to `IDLE`.
- `soc` while in `RUN` is ignored.
- `soc` still high when `eoc` returns to 1 starts a new conversion on that edge. The producer must drop `soc` once it sees `eoc`=0.
- `x` is sampled only on the load edge. Later changes to `x` do not affect a conversion in progress.
- Boundaries:
  - The all-zero or all-nine operand reduces to `len`=1 and never below.
  - A result with `len`=1 is never checked further; there is no pair left to check.
  - A digit value of 9 in the next-digit position with MSD 9 is reducible.
  - A next digit of exactly 5 is reducible only under MSD 9.

## Timing
- Reset values: `eoc`=1, `z`=0, `len`=1, `err`=0, state `IDLE`.
- Reset acts asynchronously at any time, including mid-`RUN`. The result in progress is discarded and no `eoc` pulse is produced for it.
- Latency for k reductions (0 ≤ k ≤ N−1):
  - Edge E0 samples `soc` and loads.
  - Edges E1..Ek shift.
  - Edge Ek+1 sets `eoc`=1.
  - So `eoc` is low for exactly k+1 cycles.
- Error case: `eoc` is low for exactly 1 cycle, with `z`=x and `len`=N.
- `z`, `len` and `err` are valid and stable whenever `eoc`=1. They change only on a load edge or during `RUN`.
- There is no combinational path from `soc` or `x` to any output.

## Test plan
- Reset asserted → `eoc`=1, `z`=16'h0000, `len`=1, `err`=0.
- N=4, x=16'h0042, `soc` pulse → `z`=16'h4200, `len`=2, `err`=0, `eoc` low 3 cycles.
- x=16'h9973 (−27) → `z`=16'h7300, `len`=2, `eoc` low 3 cycles. Then x=16'h0051 → `z`=16'h0510, `len`=3, `eoc` low 2 cycles.
- x=16'h0000 → `len`=1, `z`=16'h0000, `eoc` low 4 cycles. Separately, x=16'h4999 → `len`=4, `z`=16'h4999, `eoc` low 1 cycle.
- x=16'h12A4 → `err`=1, `len`=4, `z`=16'h12A4, `eoc` low 1 cycle. The next conversion with x=16'h0007 clears `err`: `len`=1, `z`=16'h7000.
- x=16'h0003:
  - Pulse `soc` again during `RUN` → ignored; the result is `len`=1, `z`=16'h3000.
  - Repeat, and assert `reset` after the first shift → outputs return to the reset values immediately.
  - A fresh `soc` then completes normally.
